// File: rtl/ram_sp_stream_ctrl.sv
// ram_sp_stream_ctrl: zero-fills a single-port byte-enable RAM after reset, then
// arbitrates write/read request streams onto its port and returns read data on a stream.
module ram_sp_stream_ctrl #(
    parameter  int ADDR_BITS = 10,
    parameter  int DATA_BITS = 64,
    localparam int STRB      = DATA_BITS / 8
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 s_wr_valid,
    output logic                 s_wr_ready,
    input  logic [ADDR_BITS-1:0] s_wr_addr,
    input  logic [DATA_BITS-1:0] s_wr_data,
    input  logic [STRB-1:0]      s_wr_strb,
    input  logic                 s_rd_valid,
    output logic                 s_rd_ready,
    input  logic [ADDR_BITS-1:0] s_rd_addr,
    output logic                 m_rd_valid,
    input  logic                 m_rd_ready,
    output logic [DATA_BITS-1:0] m_rd_data,
    output logic                 init_done,
    output logic                 ram_en,
    output logic [STRB-1:0]      ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_wdata,
    input  logic [DATA_BITS-1:0] ram_rdata
);
    typedef enum logic {INIT, RUN} state_t;
    state_t                 state, state_n;
    logic [ADDR_BITS-1:0]   init_cnt;
    logic                   inflight, last_rd;
    logic [DATA_BITS-1:0]   fifo [3];
    logic [1:0]             wp, rp, count;
    logic [2:0]             occ;
    logic                   run, rd_ok, rd_elig, wr_hs, rd_hs, push, pop;

    // A read may only issue if its response is guaranteed a FIFO slot.
    assign occ        = {1'b0, count} + {2'b0, inflight};
    assign rd_ok      = occ < 3'd3;
    assign run        = aresetn && state == RUN;
    assign rd_elig    = s_rd_valid && rd_ok;
    assign s_wr_ready = run && (!rd_elig || last_rd);
    assign s_rd_ready = run && rd_ok && (!s_wr_valid || !last_rd);
    assign wr_hs      = s_wr_valid && s_wr_ready;
    assign rd_hs      = s_rd_valid && s_rd_ready;
    assign push       = inflight;
    assign m_rd_valid = count != 2'd0;
    assign m_rd_data  = fifo[rp];
    assign pop        = m_rd_valid && m_rd_ready;

    always_comb begin
        state_n   = state;
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = s_wr_addr;
        ram_wdata = s_wr_data;
        if (aresetn && state == INIT) begin
            ram_en    = 1'b1;
            ram_we    = '1;
            ram_addr  = init_cnt;
            ram_wdata = '0;
            state_n   = init_cnt == '1 ? RUN : INIT;
        end else if (wr_hs) begin
            ram_en = 1'b1;
            ram_we = s_wr_strb;
        end else if (rd_hs) begin
            ram_en   = 1'b1;
            ram_addr = s_rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= INIT;
            init_cnt  <= '0;
            inflight  <= 1'b0;
            last_rd   <= 1'b0;
            wp        <= 2'd0;
            rp        <= 2'd0;
            count     <= 2'd0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            init_done <= state_n == RUN;
            init_cnt  <= state == INIT ? init_cnt + 1'b1 : init_cnt;
            inflight  <= rd_hs;
            last_rd   <= (wr_hs || rd_hs) ? rd_hs : last_rd;
            wp        <= push ? (wp == 2'd2 ? 2'd0 : wp + 2'd1) : wp;
            rp        <= pop ? (rp == 2'd2 ? 2'd0 : rp + 2'd1) : rp;
            count     <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (aresetn && push)
            fifo[wp] <= ram_rdata;
    end
endmodule

// File: tb/tb_ram_sp_stream_ctrl.sv
// tb_ram_sp_stream_ctrl: directed stimulus with a response scoreboard for ram_sp_stream_ctrl,
// including a behavioural byte-enable RAM with 1-cycle registered read.
module tb_ram_sp_stream_ctrl;
    logic        clk = 1'b0;
    logic        aresetn;
    logic        s_wr_valid, s_wr_ready, s_rd_valid, s_rd_ready;
    logic [3:0]  s_wr_addr, s_rd_addr, s_wr_strb;
    logic [31:0] s_wr_data, m_rd_data;
    logic        m_rd_valid, m_rd_ready, init_done, ram_en;
    logic [3:0]  ram_we, ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [31:0] mem [16];
    logic [31:0] exp_q [$];
    int          passed = 0, total = 0, pops = 0;

    ram_sp_stream_ctrl #(.ADDR_BITS(4), .DATA_BITS(32)) dut (
        .clk(clk), .aresetn(aresetn),
        .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_wr_addr(s_wr_addr),
        .s_wr_data(s_wr_data), .s_wr_strb(s_wr_strb),
        .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready), .s_rd_addr(s_rd_addr),
        .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_data(m_rd_data),
        .init_done(init_done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endfunction

    always @(negedge clk) begin
        if (aresetn && m_rd_valid && m_rd_ready) begin
            pops++;
            if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_data", m_rd_data, exp_q.pop_front());
        end
    end

    // A pending push into a full FIFO with no pop would lose a response.
    always @(negedge clk) begin
        if (aresetn && dut.inflight && !(m_rd_valid && m_rd_ready))
            assert (dut.count != 2'd3) else begin
                total++;
                $display("FAIL fifo_overflow: count %0d with push pending", dut.count);
            end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s_wr_valid = 1'b1; s_wr_addr = a; s_wr_data = d; s_wr_strb = s;
        @(negedge clk);
        while (!s_wr_ready && n < 50) begin n++; @(negedge clk); end
        check("wr_hs", n < 50, 1);
        @(posedge clk); #1 s_wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        int n = 0;
        s_rd_valid = 1'b1; s_rd_addr = a;
        @(negedge clk);
        while (!s_rd_ready && n < 50) begin n++; @(negedge clk); end
        check("rd_hs", n < 50, 1);
        if (n < 50) exp_q.push_back(e);
        @(posedge clk); #1 s_rd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic init_seq();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("init_cyc", {ram_en, ram_we, ram_addr, ram_wdata, init_done, s_wr_ready, s_rd_ready},
                  {1'b1, 4'hF, 4'(i), 32'h0, 3'b000});
        end
        @(negedge clk);
        check("init_done", {init_done, ram_en}, 2'b10);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nw = 0, nr = 0, hs = 0, k = 0, p0 = 0, n = 0;
        logic [1:0] g;
        logic took;
        aresetn = 1'b0; m_rd_ready = 1'b1;
        s_wr_valid = 1'b1; s_wr_addr = '0; s_wr_data = '0; s_wr_strb = '0;
        s_rd_valid = 1'b1; s_rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {s_wr_ready, s_rd_ready, m_rd_valid, init_done, ram_en, ram_we}, 0);
        s_wr_valid = 1'b0; s_rd_valid = 1'b0;
        aresetn = 1'b1;
        init_seq();

        // contention: read wins first because last grant after reset is write
        s_wr_valid = 1'b1; s_wr_addr = 4'd7; s_wr_data = 32'h77; s_wr_strb = 4'hF;
        s_rd_valid = 1'b1; s_rd_addr = 4'd8;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            g = {s_wr_ready && s_wr_valid, s_rd_ready && s_rd_valid};
            check("contend", g, (j % 2) ? 2'b10 : 2'b01);
            if (g[0]) begin nr++; exp_q.push_back(32'h0); end
            if (g[1]) nw++;
            @(posedge clk); #1;
        end
        s_wr_valid = 1'b0; s_rd_valid = 1'b0;
        check("contend_cnt", {nw[7:0], nr[7:0]}, {8'd4, 8'd4});
        rd(4'd7, 32'h77);
        drain();

        wr(4'd5, 32'hDEADBEEF, 4'hF);
        rd(4'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("lat_t1", m_rd_valid, 0);
        @(negedge clk);
        check("lat_t2", {m_rd_valid, m_rd_data}, {1'b1, 32'hDEADBEEF});
        @(posedge clk); #1;
        drain();

        wr(4'd3, 32'h11223344, 4'hF);
        wr(4'd3, 32'hAABBCCDD, 4'b0101);
        rd(4'd3, 32'h11BB33DD);
        wr(4'd3, 32'hFFFFFFFF, 4'h0);
        rd(4'd3, 32'h11BB33DD);
        drain();

        // backpressure: 10 reads, sink stalled for 8 cycles then released
        for (int i = 0; i < 10; i++) wr(4'(i), 32'h100 + i, 4'hF);
        m_rd_ready = 1'b0; s_rd_valid = 1'b1; s_rd_addr = 4'd0;
        for (int j = 0; j < 30; j++) begin
            if (j == 8) begin
                check("bp_stall", {hs[7:0], m_rd_valid, s_rd_ready}, {8'd3, 2'b10});
                m_rd_ready = 1'b1; p0 = pops;
            end
            if (j == 18) check("bp_rate", pops - p0, 10);
            @(negedge clk);
            took = s_rd_valid && s_rd_ready;
            if (took) begin exp_q.push_back(32'h100 + k); hs++; end
            @(posedge clk); #1;
            if (took) begin k++; s_rd_addr = 4'(k); s_rd_valid = k < 10; end
        end
        s_rd_valid = 1'b0;
        check("bp_total", hs, 10);
        drain();

        // reset with two responses queued and one read in flight
        m_rd_ready = 1'b0; s_rd_valid = 1'b1; s_rd_addr = 4'd5; hs = 0;
        while (hs < 3 && n < 20) begin
            @(negedge clk);
            if (s_rd_ready) hs++;
            @(posedge clk); #1; n++;
        end
        check("mid_pending", {hs[7:0], m_rd_valid, dut.inflight}, {8'd3, 2'b11});
        aresetn = 1'b0; s_rd_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_flush", {m_rd_valid, ram_en, s_rd_ready}, 3'b000);
        exp_q.delete();
        m_rd_ready = 1'b1;
        aresetn = 1'b1;
        init_seq();
        rd(4'd5, 32'h0);
        rd(4'd7, 32'h0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
